// File: rtl/mips_defs.sv
// Shared definitions for the 5-stage MIPS core: hazard FSM encodings,
// architectural constants and default hazard-controller parameters.
package mips_defs;

  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_LOAD_STALL = 2'd1,
    HZ_MDU_WAIT   = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 4;
  localparam int         PERF_W_DEF  = 16;

endpackage

// File: rtl/load_use_detect.sv
// Load-use dependency check between the load in EX and the instruction in ID.
module load_use_detect
  import mips_defs::*;
(
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       load_use_o
);

  logic rs_hit, rt_hit;

  assign rs_hit = (ex_rt_i == id_rs_i);
  // rt only matters when ID actually sources it (e.g. not the lw/addi target)
  assign rt_hit = id_uses_rt_i && (ex_rt_i == id_rt_i);

  // $0 is hardwired, so a load into it carries no dependency
  assign load_use_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Front-end hazard controller: load-use stall, taken-branch squash, MDU wait
// bubbles and a saturating count of bubble cycles.
module hazard_ctrl
  import mips_defs::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int PERF_W  = PERF_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_uses_rt,
  input  logic              id_mdu_op,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_rt,
  input  logic              ex_branch_taken,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              bubble,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] perf_stalls
);

  localparam int               CNT_W    = $clog2(MDU_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  hz_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              load_use;

  load_use_detect u_lud (
    .ex_mem_read_i (ex_mem_read),
    .ex_rt_i       (ex_rt),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rt_i  (id_uses_rt),
    .load_use_o    (load_use)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    bubble     = 1'b0;
    mdu_busy   = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        if (ex_branch_taken) begin
          // flush also kills any dependent instruction, so no load stall
          ifid_flush = 1'b1;
          bubble     = 1'b1;
        end else if (load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          bubble     = 1'b1;
          state_d    = HZ_LOAD_STALL;
        end else if (id_mdu_op) begin
          cnt_d   = CNT_LOAD;
          state_d = HZ_MDU_WAIT;
        end
      end
      HZ_LOAD_STALL: state_d = HZ_RUN;
      HZ_MDU_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        bubble     = 1'b1;
        mdu_busy   = 1'b1;
        if (cnt_q == '0) state_d = HZ_RUN;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = HZ_RUN;
    endcase
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      bubble     = 1'b1;
      mdu_busy   = 1'b0;
    end
  end

  always_comb begin
    perf_d = perf_q;
    if (bubble && (perf_q != '1)) perf_d = perf_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
      perf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      perf_q  <= perf_d;
    end
  end

  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scenarios plus randomized traffic checked against a cycle model
// that tracks pending bubble cycles with plain integers.
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int PERF_W  = 4;
  localparam int PERF_MAX = (1 << PERF_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [4:0]        id_rs = '0, id_rt = '0, ex_rt = '0;
  logic              id_uses_rt = 1'b0, id_mdu_op = 1'b0, ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic              pc_write, ifid_write, ifid_flush, bubble, mdu_busy;
  logic [PERF_W-1:0] perf_stalls;

  int n_chk = 0;
  int n_err = 0;

  // reference model state
  int m_mdu_left = 0;   // MDU bubble cycles still owed
  bit m_ld_free  = 0;   // cycle after a load stall: hazards ignored
  int m_perf     = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(MDU_LAT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_mdu_op(id_mdu_op),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .bubble(bubble), .mdu_busy(mdu_busy), .perf_stalls(perf_stalls)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                      input bit mdu, input bit mr, input logic [4:0] ert, input bit br);
    bit e_pc, e_if, e_fl, e_bub, e_busy, lu;
    @(posedge clk);
    #1;
    reset = r; id_rs = rs; id_rt = rt; id_uses_rt = urt; id_mdu_op = mdu;
    ex_mem_read = mr; ex_rt = ert; ex_branch_taken = br;
    #3;
    e_pc = 1; e_if = 1; e_fl = 0; e_bub = 0; e_busy = 0;
    lu = mr && (ert != 0) && ((ert == rs) || (urt && ert == rt));
    if (r) begin
      e_pc = 0; e_if = 0; e_fl = 1; e_bub = 1;
    end else if (m_mdu_left > 0) begin
      e_pc = 0; e_if = 0; e_bub = 1; e_busy = 1;
    end else if (!m_ld_free) begin
      if (br) begin
        e_fl = 1; e_bub = 1;
      end else if (lu) begin
        e_pc = 0; e_if = 0; e_bub = 1;
      end
    end
    chk("pc_write", pc_write, e_pc);
    chk("ifid_write", ifid_write, e_if);
    chk("ifid_flush", ifid_flush, e_fl);
    chk("bubble", bubble, e_bub);
    chk("mdu_busy", mdu_busy, e_busy);
    chk("perf_stalls", perf_stalls, m_perf);
    if (r) begin
      m_mdu_left = 0; m_ld_free = 0; m_perf = 0;
    end else begin
      if (e_bub && m_perf < PERF_MAX) m_perf++;
      if (m_mdu_left > 0)   m_mdu_left--;
      else if (m_ld_free)   m_ld_free = 0;
      else if (br)          ;
      else if (lu)          m_ld_free = 1;
      else if (mdu)         m_mdu_left = MDU_LAT;
    end
  endtask

  task automatic idle();
    step(0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0);
  endtask

  task automatic do_reset();
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    do_reset();

    // load-use: lw $8 in EX, ID reads $8 via rs
    step(0, 5'd8, 5'd3, 0, 0, 1, 5'd8, 0);
    chk("lu_pc_hold", pc_write, 0);
    step(0, 5'd8, 5'd3, 0, 0, 1, 5'd8, 0);   // LOAD_STALL ignores the still-present match
    chk("lu_after_default", pc_write, 1);
    idle();
    chk("lu_perf", perf_stalls, 1);

    // zero register and unused rt
    do_reset();
    step(0, 5'd0, 5'd4, 1, 0, 1, 5'd0, 0);
    chk("zero_no_stall", bubble, 0);
    step(0, 5'd4, 5'd9, 0, 0, 1, 5'd9, 0);
    chk("rt_unused_no_stall", pc_write, 1);
    step(0, 5'd4, 5'd9, 1, 0, 1, 5'd9, 0);
    chk("rt_used_stall", pc_write, 0);

    // branch beats load-use; next cycle still in RUN so the match stalls
    do_reset();
    step(0, 5'd7, 5'd0, 0, 0, 1, 5'd7, 1);
    chk("br_flush", ifid_flush, 1);
    chk("br_pc", pc_write, 1);
    step(0, 5'd7, 5'd0, 0, 0, 1, 5'd7, 0);
    chk("br_then_run_stall", ifid_write, 0);

    // MDU wait: issue cycle, then MDU_LAT busy cycles
    do_reset();
    step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
    chk("mdu_issue_default", bubble, 0);
    for (int i = 0; i < MDU_LAT; i++) begin
      idle();
      chk("mdu_busy_cycle", mdu_busy, 1);
    end
    idle();
    chk("mdu_done", mdu_busy, 0);
    chk("mdu_perf", perf_stalls, MDU_LAT);

    // load-use together with MDU op: stall first, MDU re-evaluated later
    do_reset();
    step(0, 5'd5, 5'd0, 0, 1, 1, 5'd5, 0);
    step(0, 5'd5, 5'd0, 0, 1, 0, 5'd0, 0);
    chk("lu_mdu_stall_slot", mdu_busy, 0);
    step(0, 5'd5, 5'd0, 0, 1, 0, 5'd0, 0);
    chk("lu_mdu_issue", bubble, 0);
    idle();
    chk("lu_mdu_wait", mdu_busy, 1);

    // reset in the 2nd MDU_WAIT cycle
    do_reset();
    step(0, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0);
    idle();
    step(1, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0);
    chk("rst_mid_flush", ifid_flush, 1);
    chk("rst_mid_busy", mdu_busy, 0);
    idle();
    chk("rst_after_busy", mdu_busy, 0);
    chk("rst_after_perf", perf_stalls, 0);

    // saturation of the 4-bit counter
    do_reset();
    for (int i = 0; i < 20; i++) step(0, 5'd1, 5'd2, 1, 0, 0, 5'd0, 1);
    idle();
    chk("perf_sat", perf_stalls, 4'hF);

    // randomized traffic over a small register window so matches are frequent
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 7) == 0), 1'($urandom),
           5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
